mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT_CYC, 15, maximum BUSY cycles allowed while waiting for mem_ready.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- halt  in  1  while high, no new fetch grants.
- if_req  in  1  instruction-fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted (1-cycle pulse).
- if_valid  out  1  if_rdata valid (1-cycle pulse).
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  LOAD/STORE request; held until d_gnt.
- d_we  in  1  1 = STORE, 0 = LOAD.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  STORE data.
- d_gnt  out  1  data request accepted (1-cycle pulse).
- d_valid  out  1  data transaction complete (1-cycle pulse).
- d_rdata  out  DATA_W  LOAD data.
- err  out  1  timeout; pulses together with the completing valid.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the access this cycle.

Function
REQ-003 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE, with owner register own (0 = fetch, 1 = data).
REQ-004 In IDLE, if d_req is high, the block SHALL grant data: d_gnt=1 for that cycle, own=1, and next state BUSY.
REQ-005 In IDLE, if d_req is low, if_req is high and halt is low, the block SHALL grant fetch: if_gnt=1, own=0, and next state BUSY.
REQ-006 When both requests are high in IDLE, data SHALL win, since the data access is older in the pipeline.
REQ-007 On grant, the block SHALL register mem_addr/mem_we/mem_wdata from the winner (mem_we=0 and mem_wdata held for fetch), and mem_en SHALL be 1 throughout BUSY.
REQ-008 In BUSY, when mem_ready=1 the block SHALL capture mem_rdata into the owner's rdata register, drop mem_en, and go to DONE.
REQ-009 In DONE, the block SHALL pulse the owner's valid for exactly one cycle, then return to IDLE; the minimum grant-to-grant spacing is therefore 3 cycles.
REQ-010 For a STORE, d_valid SHALL still pulse, and d_rdata SHALL keep its previous value.
REQ-011 A BUSY wait counter SHALL count cycles spent in BUSY.
REQ-012 If the wait counter reaches TIMEOUT_CYC without mem_ready, the block SHALL drop mem_en and go to DONE with rdata unchanged, and err SHALL pulse together with the owner's valid.
REQ-013 mem_ready seen outside BUSY SHALL be ignored.
REQ-014 Changes on halt during BUSY/DONE SHALL NOT affect the in-flight fetch.
REQ-015 if_rdata and d_rdata SHALL hold their values between transactions.
REQ-016 gnt and valid SHALL never be asserted for both requesters in the same cycle.

Reset
REQ-017 While rst is high at a clock edge: state=IDLE, own=0, wait counter=0, and all outputs 0 (if_rdata, d_rdata, mem_addr and mem_wdata included).
REQ-018 Reset in BUSY/DONE SHALL abort the transaction with no valid pulse, and grants SHALL resume from the first non-reset cycle.

Configuration
REQ-019 The macro MEM_ARB_FAIRNESS_EN SHALL select the fairness feature.
REQ-020 With MEM_ARB_FAIRNESS_EN defined, a 2-bit consecutive-data-grant counter SHALL run:
- it increments on each data grant and clears on each fetch grant;
- at value 3, with if_req=1 and halt=0, fetch SHALL win over d_req in IDLE.
REQ-021 Without MEM_ARB_FAIRNESS_EN, no counter SHALL exist and data SHALL always win (REQ-006).

Verification
REQ-022 Fetch only: if_req=1, if_addr=0x0010, mem_ready one cycle after grant, mem_rdata=0xA5A5 -> if_gnt, then if_valid with if_rdata=0xA5A5; mem_we=0 throughout.
REQ-023 Simultaneous requests: d_req (LOAD 0x0200) and if_req together in IDLE -> d_gnt first and mem_addr=0x0200; fetch granted on the next IDLE, 3 cycles after d_gnt.
REQ-024 STORE: d_we=1, d_addr=0x0300, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234, d_valid pulse, d_rdata unchanged.
REQ-025 Timeout: mem_ready held low -> after 15 BUSY cycles, mem_en=0, then err=1 together with the valid pulse.
REQ-026 halt=1 with if_req=1 -> no if_gnt for 20 cycles; reset asserted in BUSY -> all outputs 0 and no valid pulse.
REQ-027 With MEM_ARB_FAIRNESS_EN, d_req and if_req held high continuously -> grant order D, D, D, F, repeating.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: data (LOAD/STORE) and instruction fetch share one memory port.
// Optional fetch-fairness counter enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_r;
  logic              own_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              if_valid_r;
  logic              d_valid_r;
  logic              err_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              grant_d_s;
  logic              grant_f_s;
  logic              timeout_s;
  logic              fair_force_s;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [1:0] fair_cnt_r;

  assign fair_force_s = (fair_cnt_r == 2'd3) && if_req && !halt;

  // Consecutive data-grant counter; saturates so fetch keeps priority until it is served.
  always_ff @(posedge clk) begin
    if (rst) begin
      fair_cnt_r <= 2'd0;
    end else if (grant_f_s) begin
      fair_cnt_r <= 2'd0;
    end else if (grant_d_s && (fair_cnt_r != 2'd3)) begin
      fair_cnt_r <= fair_cnt_r + 2'd1;
    end else begin
      fair_cnt_r <= fair_cnt_r;
    end
  end
`else
  assign fair_force_s = 1'b0;
`endif

  // Grant decision: only in IDLE and never while reset is asserted.
  always_comb begin
    grant_d_s = 1'b0;
    grant_f_s = 1'b0;
    if (!rst && (state_r == ST_IDLE)) begin
      if (d_req && !fair_force_s) begin
        grant_d_s = 1'b1;
      end else if (if_req && !halt) begin
        grant_f_s = 1'b1;
      end else begin
        grant_d_s = 1'b0;
        grant_f_s = 1'b0;
      end
    end else begin
      grant_d_s = 1'b0;
      grant_f_s = 1'b0;
    end
  end

  assign timeout_s = (state_r == ST_BUSY) && !mem_ready && (wait_cnt_r == WAIT_LAST);

  // Transaction FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      own_r       <= 1'b0;
      wait_cnt_r  <= '0;
      if_valid_r  <= 1'b0;
      d_valid_r   <= 1'b0;
      err_r       <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rdata_r  <= '0;
      d_rdata_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if_valid_r <= 1'b0;
          d_valid_r  <= 1'b0;
          err_r      <= 1'b0;
          wait_cnt_r <= '0;
          if (grant_d_s) begin
            own_r       <= 1'b1;
            mem_en_r    <= 1'b1;
            mem_we_r    <= d_we;
            mem_addr_r  <= d_addr;
            mem_wdata_r <= d_wdata;
            state_r     <= ST_BUSY;
          end else if (grant_f_s) begin
            own_r      <= 1'b0;
            mem_en_r   <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= if_addr;
            state_r    <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            if (!own_r) begin
              if_rdata_r <= mem_rdata;
            end else if (!mem_we_r) begin
              d_rdata_r <= mem_rdata;
            end else begin
              d_rdata_r <= d_rdata_r;
            end
            mem_en_r   <= 1'b0;
            if_valid_r <= !own_r;
            d_valid_r  <= own_r;
            state_r    <= ST_DONE;
          end else if (timeout_s) begin
            mem_en_r   <= 1'b0;
            err_r      <= 1'b1;
            if_valid_r <= !own_r;
            d_valid_r  <= own_r;
            state_r    <= ST_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if_valid_r <= 1'b0;
          d_valid_r  <= 1'b0;
          err_r      <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          if_valid_r <= 1'b0;
          d_valid_r  <= 1'b0;
          err_r      <= 1'b0;
          mem_en_r   <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_gnt    = grant_f_s;
  assign d_gnt     = grant_d_s;
  assign if_valid  = if_valid_r;
  assign d_valid   = d_valid_r;
  assign err       = err_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change 1 ns after the rising
// edge and outputs are sampled 1 ns later.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [15:0] d_rdata;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int checks;
  int errors;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; if_req = 1'b1; if_addr = 16'h0001;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    mem_rdata = 16'h0000; mem_ready = 1'b0;
    tick(); tick();
    settle();
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt: got %b want 0", if_gnt); end
    checks++; if ({d_gnt, if_valid, d_valid, err, mem_en, mem_we} !== 6'b000000) begin errors++; $display("FAIL reset_flags: got %b want 000000", {d_gnt, if_valid, d_valid, err, mem_en, mem_we}); end
    checks++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_buses: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); end
    if_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 16'h0010;
    settle();
    checks++; if ({if_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt, d_gnt}); end
    tick();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    settle();
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin errors++; $display("FAIL fetch_busy: got en=%b we=%b addr=%h want 1 0 0010", mem_en, mem_we, mem_addr); end
    tick();
    mem_ready = 1'b0;
    settle();
    checks++; if ({if_valid, d_valid, err, mem_en, mem_we} !== 5'b10000) begin errors++; $display("FAIL fetch_done_flags: got %b want 10000", {if_valid, d_valid, err, mem_en, mem_we}); end
    checks++; if (if_rdata !== 16'hA5A5) begin errors++; $display("FAIL fetch_rdata: got %h want a5a5", if_rdata); end
    tick();
    settle();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_pulse: got %b want 0", if_valid); end
  endtask

  task automatic test_simultaneous();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200; if_req = 1'b1; if_addr = 16'h0020;
    settle();
    checks++; if ({d_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL simul_first_gnt: got d=%b f=%b want d=1 f=0", d_gnt, if_gnt); end
    tick();
    d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    settle();
    checks++; if ({mem_addr, if_gnt} !== {16'h0200, 1'b0}) begin errors++; $display("FAIL simul_busy: got addr=%h if_gnt=%b want 0200 0", mem_addr, if_gnt); end
    tick();
    mem_ready = 1'b0;
    settle();
    checks++; if ({d_valid, if_valid, if_gnt, d_rdata} !== {3'b100, 16'h5A5A}) begin errors++; $display("FAIL simul_done: got dv=%b iv=%b ig=%b rd=%h want 1 0 0 5a5a", d_valid, if_valid, if_gnt, d_rdata); end
    tick();
    settle();
    checks++; if ({if_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL simul_second_gnt: got f=%b d=%b want f=1 d=0", if_gnt, d_gnt); end
    tick();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h1111;
    settle();
    checks++; if (mem_addr !== 16'h0020) begin errors++; $display("FAIL simul_fetch_addr: got %h want 0020", mem_addr); end
    tick();
    mem_ready = 1'b0;
    settle();
    checks++; if ({if_valid, if_rdata, d_rdata} !== {1'b1, 16'h1111, 16'h5A5A}) begin errors++; $display("FAIL simul_fetch_done: got v=%b if=%h d=%h want 1 1111 5a5a", if_valid, if_rdata, d_rdata); end
    tick();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h1234;
    settle();
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt: got %b want 1", d_gnt); end
    tick();
    d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    settle();
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0300, 16'h1234}) begin errors++; $display("FAIL store_busy: got en=%b we=%b a=%h wd=%h want 1 1 0300 1234", mem_en, mem_we, mem_addr, mem_wdata); end
    tick();
    mem_ready = 1'b0;
    settle();
    checks++; if ({d_valid, err, d_rdata} !== {2'b10, 16'h5A5A}) begin errors++; $display("FAIL store_done: got v=%b err=%b rd=%h want 1 0 5a5a", d_valid, err, d_rdata); end
    tick();
    d_we = 1'b0;
  endtask

  task automatic test_timeout();
    if_req = 1'b1; if_addr = 16'h0040; mem_ready = 1'b0; mem_rdata = 16'hBEEF;
    settle();
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL timeout_gnt: got %b want 1", if_gnt); end
    tick();
    if_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      settle();
      checks++; if ({mem_en, if_valid, err} !== 3'b100) begin errors++; $display("FAIL timeout_busy_%0d: got en=%b v=%b err=%b want 1 0 0", i, mem_en, if_valid, err); end
      tick();
    end
    settle();
    checks++; if ({mem_en, err, if_valid, d_valid} !== 4'b0110) begin errors++; $display("FAIL timeout_done: got en=%b err=%b iv=%b dv=%b want 0 1 1 0", mem_en, err, if_valid, d_valid); end
    checks++; if (if_rdata !== 16'h1111) begin errors++; $display("FAIL timeout_rdata: got %h want 1111", if_rdata); end
    tick();
    settle();
    checks++; if ({err, if_valid} !== 2'b00) begin errors++; $display("FAIL timeout_after: got err=%b v=%b want 0 0", err, if_valid); end
  endtask

  task automatic test_halt();
    halt = 1'b1; if_req = 1'b1; if_addr = 16'h0060; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    for (int i = 0; i < 20; i++) begin
      settle();
      checks++; if ({if_gnt, if_valid, mem_en} !== 3'b000) begin errors++; $display("FAIL halt_hold_%0d: got g=%b v=%b en=%b want 0 0 0", i, if_gnt, if_valid, mem_en); end
      tick();
    end
    checks++; if (if_rdata !== 16'h1111) begin errors++; $display("FAIL halt_idle_ready: got %h want 1111", if_rdata); end
    halt = 1'b0; mem_ready = 1'b0;
    settle();
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL halt_release_gnt: got %b want 1", if_gnt); end
    tick();
    if_req = 1'b0; halt = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ready = 1'b0;
    settle();
    checks++; if ({if_valid, if_rdata} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL halt_inflight: got v=%b rd=%h want 1 2222", if_valid, if_rdata); end
    halt = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400; mem_ready = 1'b0;
    settle();
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rstbusy_gnt: got %b want 1", d_gnt); end
    tick();
    d_req = 1'b0;
    settle();
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rstbusy_en: got %b want 1", mem_en); end
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h3333; if_req = 1'b1; if_addr = 16'h0070;
    tick();
    settle();
    checks++; if ({if_gnt, d_gnt, if_valid, d_valid, err, mem_en, mem_we} !== 7'b0) begin errors++; $display("FAIL rstbusy_flags: got %b want 0000000", {if_gnt, d_gnt, if_valid, d_valid, err, mem_en, mem_we}); end
    checks++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL rstbusy_buses: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); end
    rst = 1'b0; mem_ready = 1'b0;
    settle();
    checks++; if ({if_gnt, d_valid} !== 2'b10) begin errors++; $display("FAIL rstbusy_resume: got g=%b dv=%b want 1 0", if_gnt, d_valid); end
    tick();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h4444;
    tick();
    mem_ready = 1'b0;
    settle();
    checks++; if ({if_valid, d_valid, if_rdata, d_rdata} !== {2'b10, 16'h4444, 16'h0000}) begin errors++; $display("FAIL rstbusy_after: got iv=%b dv=%b if=%h d=%h want 1 0 4444 0000", if_valid, d_valid, if_rdata, d_rdata); end
    tick();
  endtask

  task automatic test_priority();
    logic [7:0] exp_f;
`ifdef MEM_ARB_FAIRNESS_EN
    exp_f = 8'b1000_1000;
`else
    exp_f = 8'b0000_0000;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500; if_req = 1'b1; if_addr = 16'h0050;
    mem_ready = 1'b1; mem_rdata = 16'h6666;
    for (int i = 0; i < 8; i++) begin
      settle();
      checks++; if ({if_gnt, d_gnt} !== {exp_f[i], ~exp_f[i]}) begin errors++; $display("FAIL priority_slot_%0d: got f=%b d=%b want f=%b d=%b", i, if_gnt, d_gnt, exp_f[i], ~exp_f[i]); end
      tick();
      settle();
      checks++; if ({if_gnt, d_gnt} !== 2'b00) begin errors++; $display("FAIL priority_busy_%0d: got f=%b d=%b want 0 0", i, if_gnt, d_gnt); end
      tick();
      settle();
      checks++; if ({if_valid, d_valid} !== {exp_f[i], ~exp_f[i]}) begin errors++; $display("FAIL priority_valid_%0d: got iv=%b dv=%b want %b %b", i, if_valid, d_valid, exp_f[i], ~exp_f[i]); end
      tick();
    end
    d_req = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_timeout();
    test_halt();
    test_reset_busy();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
